uart_rx_oversample: RTL
=======================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-006 SHALL have port rx_data  output  8  last received byte; held until the next rx_valid.
REQ-007 SHALL have port rx_valid  output  1  one-cycle strobe per completed frame.
REQ-008 SHALL have port rx_ferr  output  1  frame error (stop bit sampled 0); valid only in the rx_valid cycle.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-010 SHALL derive a 16x oversample tick every DIV = round(CLK_FREQ_HZ/(16*BAUD)) clocks (54 at defaults; bit period 864 clocks).
REQ-011 SHALL hold the tick divider and the tick counter at 0 in IDLE, and start both on the first clock where rxd_s==0, so bit windows are aligned to the detected start edge.
REQ-012 SHALL split each bit into a 16-tick window (ticks 0..15) and take the bit decision at tick 8 of every window.
REQ-013 SHALL implement states IDLE, START, DATA, STOP and BREAK.
- IDLE->START on rxd_s==0.
- START: decision 0 -> DATA; decision 1 -> IDLE (false start, no output).
- DATA: shift in 8 decisions, LSB first; after the 8th -> STOP.
- STOP: at the decision, load rx_data from the shift register, pulse rx_valid, and set rx_ferr = ~decision.
- STOP with decision 1 -> IDLE; with decision 0 -> BREAK.
- BREAK->IDLE on the first clock with rxd_s==1.
REQ-014 SHALL keep rx_valid high for exactly one clock per frame, including frames with rx_ferr=1.
REQ-015 SHALL keep rx_ferr low in every cycle where rx_valid is low.
REQ-016 SHALL return to IDLE at the stop-bit decision, so a start edge in the second half of the stop bit is accepted: back-to-back frames with no idle gap.
REQ-017 SHALL assert rx_valid 9.5 bit periods (+-1 tick) plus synchronizer latency (2-3 clocks) after the rxd falling edge.
REQ-018 SHALL never produce rx_valid for a low pulse on an idle line shorter than half a bit period.

Reset
REQ-019 SHALL, while rst_n==0, force the following regardless of clk:
- state = IDLE;
- rx_data = 8'h00, rx_valid = 0, rx_ferr = 0;
- synchronizer flops = 1;
- divider, tick counter, bit counter and shift register = 0.
REQ-020 SHALL discard a frame interrupted by reset without emitting rx_valid; after reset release, reception restarts from IDLE on the next start edge.

Configuration
REQ-021 SHALL support macro UART_RX_MAJORITY_EN.
- Defined: each bit decision is the 2-of-3 majority of rxd_s at ticks 7, 8 and 9, taken at tick 9; all other timing shifts by one tick.
- Undefined: the decision is the single rxd_s value at tick 8 (REQ-012).
- Ports are identical in both builds.

Structure
REQ-022 SHALL take the state encoding, the OVERSAMPLE=16 constant and the DIV rounding function from the shared package uart_pkg, which is also used by the UART transmitter.
REQ-023 SHALL instantiate one sub-module, uart_baud_tick (divider with a synchronous restart input and a tick output); all remaining logic stays in uart_rx_oversample.

Verification
REQ-024 SHALL drive 0xAA at 864 clocks/bit -> exactly one rx_valid, rx_data=0xAA, rx_ferr=0, about 8210 clocks after the start edge.
REQ-025 SHALL drive 0xAA, 0x01, 0x7F, 0x80 back-to-back with no idle gap -> four rx_valid pulses, each with the correct data and rx_ferr=0.
REQ-026 SHALL drive 0x55 with the stop bit 0 and the line held low for 2 further bit periods, then high -> one rx_valid with rx_data=0x55 and rx_ferr=1, and no further rx_valid until a new start bit.
REQ-027 SHALL drive a 300-clock low glitch on an idle line -> no rx_valid, state back in IDLE.
REQ-028 SHALL assert rst_n=0 during data bit 4 of 0xC3, release it, then send 0x3C -> outputs 0 during reset and only 0x3C reported.
REQ-029 SHALL, with UART_RX_MAJORITY_EN defined, invert rxd for one tick (54 clocks) at tick 8 of data bit 2 of 0x00 -> rx_data=0x00; without the macro -> rx_data=0x04.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared by the UART receiver and transmitter.
// Holds the receiver state encoding, the oversample ratio and the
// baud divider rounding helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest: round(clk_hz / (16 * baud)).
    function automatic int calc_div(input longint clk_hz, input longint baud);
        longint den;
        den = longint'(OVERSAMPLE) * baud;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_baud_tick.sv
// uart_baud_tick: free-running clock divider producing a one-cycle tick
// every DIV clocks. While restart is high the count is held at zero, so the
// first tick after restart drops arrives exactly DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == LAST);

    // Divider count: cleared on restart, wraps after DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver with 16x oversampling.
// Bit windows are re-aligned to every detected start edge; each bit is
// decided at mid-window. Optional build macro UART_RX_MAJORITY_EN switches
// the decision to a 2-of-3 vote over ticks 7, 8 and 9 (decided at tick 9).
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int DIV      = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int TW       = $clog2(OVERSAMPLE);
    localparam int DEC_TICK = OVERSAMPLE / 2;

    uart_state_t   state, state_nxt;

    logic          rxd_p0;
    logic          rxd_s;
    logic          tick;
    logic          win_clr;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          dec_now;
    logic          dec_bit;
    logic          shift_en;
    logic          frame_done;

    // Two-flop synchronizer on the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_p0 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_s  <= rxd_p0;
        end
    end

    // Oversample tick generator, held in restart while waiting for an edge.
    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (win_clr),
        .tick    (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign dec_now = tick && (tick_cnt == TW'(DEC_TICK));
    assign dec_bit = maj3(samp_a, samp_b, rxd_s);

    // Capture the line at ticks 7 and 8; tick 9 supplies the third vote live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (tick && (tick_cnt == TW'(DEC_TICK - 2))) begin
                samp_a <= rxd_s;
            end
            if (tick && (tick_cnt == TW'(DEC_TICK - 1))) begin
                samp_b <= rxd_s;
            end
        end
    end
`else
    assign dec_now = tick && (tick_cnt == TW'(DEC_TICK - 1));
    assign dec_bit = rxd_s;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt  = state;
        win_clr    = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                win_clr = 1'b1;
                if (!rxd_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (dec_now) begin
                    state_nxt = dec_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (dec_now) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (dec_now) begin
                    // Leaving at mid-stop lets a following start edge land
                    // in the second half of the stop bit.
                    frame_done = 1'b1;
                    state_nxt  = dec_bit ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                win_clr = 1'b1;
                if (rxd_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Tick position inside the current 16-tick bit window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (win_clr) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (win_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {dec_bit, shift_reg[7:1]};
            end
        end
    end

    // Output registers: byte held between frames, strobe and error one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= frame_done;
            rx_ferr  <= frame_done & ~dec_bit;
            if (frame_done) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule
